// File: rtl/max7219_receiver.sv
// MAX7219 serial-side receiver: oversamples the din/clk/load pins, assembles 16-bit
// frames and decodes them into the digit and configuration register map.
module max7219_receiver (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_din,
    input  logic       i_serial_clk,
    input  logic       i_serial_load,
    output logic       o_serial_dout,
    output logic       o_stb,
    output logic       o_err,
    output logic [3:0] o_addr,
    output logic [7:0] o_data,
    input  logic [2:0] i_digit_sel,
    output logic [7:0] o_digit,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_enable,
    output logic       o_display_test
);

    // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (previous s2, for edge detection)
    logic [1:0]  din_sync_reg;
    logic [2:0]  sclk_sync_reg;
    logic [2:0]  load_sync_reg;
    logic [15:0] shift_reg;
    logic [15:0] shift_next;
    logic [4:0]  bit_cnt_reg;
    logic [4:0]  bit_cnt_next;
    logic [7:0]  digit_reg [8];
    logic        sclk_rise;
    logic        load_rise;
    logic        frame_ok;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;
    logic [2:0]  digit_idx;

    // The shift is resolved first so a commit on the same cycle sees the post-shift frame.
    always_comb begin
        sclk_rise    = sclk_sync_reg[1] & ~sclk_sync_reg[2];
        load_rise    = load_sync_reg[1] & ~load_sync_reg[2];
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        if (sclk_rise) begin
            shift_next = {shift_reg[14:0], din_sync_reg[1]};
            if (bit_cnt_reg != 5'd17) begin
                bit_cnt_next = bit_cnt_reg + 5'd1;
            end
        end
        frame_ok   = load_rise && (bit_cnt_next == 5'd16);
        frame_addr = shift_next[11:8];
        frame_data = shift_next[7:0];
        digit_idx  = frame_addr[2:0] - 3'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            din_sync_reg   <= '0;
            sclk_sync_reg  <= '0;
            load_sync_reg  <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            o_serial_dout  <= 1'b0;
            o_stb          <= 1'b0;
            o_err          <= 1'b0;
            o_addr         <= '0;
            o_data         <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_enable       <= 1'b0;
            o_display_test <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_reg[i] <= '0;
            end
        end else begin
            din_sync_reg  <= {din_sync_reg[0], i_serial_din};
            sclk_sync_reg <= {sclk_sync_reg[1:0], i_serial_clk};
            load_sync_reg <= {load_sync_reg[1:0], i_serial_load};
            shift_reg     <= shift_next;
            o_serial_dout <= shift_next[15];
            bit_cnt_reg   <= load_rise ? 5'd0 : bit_cnt_next;
            o_stb         <= frame_ok;
            o_err         <= load_rise && !frame_ok;
            if (frame_ok) begin
                o_addr <= frame_addr;
                o_data <= frame_data;
                case (frame_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_reg[digit_idx] <= frame_data;
                    4'h9: o_decode_mode  <= frame_data;
                    4'hA: o_intensity    <= frame_data[3:0];
                    4'hB: o_scan_limit   <= frame_data[2:0];
                    4'hC: o_enable       <= frame_data[0];
                    4'hF: o_display_test <= frame_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign o_digit = digit_reg[i_digit_sel];

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver: table of serial frames with expected strobes,
// address/data and intensity, plus reset-mid-frame and daisy-chain sequences.
module tb_max7219_receiver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       din = 1'b0;
    logic       sclk = 1'b0;
    logic       load = 1'b0;
    logic       dout;
    logic       stb;
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] digit_sel = 3'd0;
    logic [7:0] digit;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       enable;
    logic       display_test;

    max7219_receiver dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_serial_din   (din),
        .i_serial_clk   (sclk),
        .i_serial_load  (load),
        .o_serial_dout  (dout),
        .o_stb          (stb),
        .o_err          (err),
        .o_addr         (addr),
        .o_data         (data),
        .i_digit_sel    (digit_sel),
        .o_digit        (digit),
        .o_decode_mode  (decode_mode),
        .o_intensity    (intensity),
        .o_scan_limit   (scan_limit),
        .o_enable       (enable),
        .o_display_test (display_test)
    );

    always #10 clk = ~clk;

    // Cycles with the strobe high; a stuck strobe shows up as a count above one.
    int stb_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (stb) stb_cnt++;
        if (err) err_cnt++;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        wait_cyc(4);
        sclk = 1'b1;
        wait_cyc(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic pulse_load();
        wait_cyc(4);
        load = 1'b1;
        wait_cyc(4);
        load = 1'b0;
        wait_cyc(6);
    endtask

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          exp_stb;
        int          exp_err;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
        logic [3:0]  exp_int;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int s0;
        int e0;
        logic [15:0] chain;

        vecs[0]  = '{32'h09FF, 16, 1, 0, 4'h9, 8'hFF, 4'h0};
        vecs[1]  = '{32'h0A07, 16, 1, 0, 4'hA, 8'h07, 4'h7};
        vecs[2]  = '{32'h0B05, 16, 1, 0, 4'hB, 8'h05, 4'h7};
        vecs[3]  = '{32'h0C01, 16, 1, 0, 4'hC, 8'h01, 4'h7};
        vecs[4]  = '{32'h0F00, 16, 1, 0, 4'hF, 8'h00, 4'h7};
        for (int k = 1; k <= 8; k++) begin
            vecs[4 + k] = '{32'((k << 8) | k), 16, 1, 0, 4'(k), 8'(k), 4'h7};
        end
        vecs[13] = '{32'h0181, 16, 1, 0, 4'h1, 8'h81, 4'h7};
        vecs[14] = '{32'h0507, 15, 0, 1, 4'h1, 8'h81, 4'h7};  // short frame
        vecs[15] = '{32'h0A0F, 17, 0, 1, 4'h1, 8'h81, 4'h7};  // long frame
        vecs[16] = '{32'h0A03, 16, 1, 0, 4'hA, 8'h03, 4'h3};
        vecs[17] = '{32'h0000, 16, 1, 0, 4'h0, 8'h00, 4'h3};
        vecs[18] = '{32'h0D55, 16, 1, 0, 4'hD, 8'h55, 4'h3};

        // Reset state
        wait_cyc(4);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_decode", 32'(decode_mode), 0);
        chk("rst_enable", 32'(enable), 0);
        reset_n = 1'b1;
        wait_cyc(4);

        for (int v = 0; v < 19; v++) begin
            s0 = stb_cnt;
            e0 = err_cnt;
            send_bits(vecs[v].word, vecs[v].nbits);
            pulse_load();
            $display("vec %0d: word=0x%0h bits=%0d stb=%0d err=%0d addr=0x%0h data=0x%0h int=%0d",
                     v, vecs[v].word, vecs[v].nbits, stb_cnt - s0, err_cnt - e0, addr, data, intensity);
            chk($sformatf("v%0d_stb", v), 32'(stb_cnt - s0), 32'(vecs[v].exp_stb));
            chk($sformatf("v%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_addr", v), 32'(addr), 32'(vecs[v].exp_addr));
            chk($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_int", v), 32'(intensity), 32'(vecs[v].exp_int));
        end

        chk("cfg_decode", 32'(decode_mode), 32'hFF);
        chk("cfg_scan", 32'(scan_limit), 5);
        chk("cfg_enable", 32'(enable), 1);
        chk("cfg_test", 32'(display_test), 0);
        for (int k = 0; k < 8; k++) begin
            digit_sel = 3'(k);
            #1;
            chk($sformatf("digit%0d", k), 32'(digit), (k == 0) ? 32'h81 : 32'(k + 1));
        end

        // Reset during a partial frame, then a clean frame
        s0 = stb_cnt;
        e0 = err_cnt;
        send_bits(32'h0A, 8);
        reset_n = 1'b0;
        wait_cyc(3);
        digit_sel = 3'd0;
        chk("mid_rst_stb", 32'(stb), 0);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_int", 32'(intensity), 0);
        chk("mid_rst_scan", 32'(scan_limit), 0);
        chk("mid_rst_digit0", 32'(digit), 0);
        reset_n = 1'b1;
        wait_cyc(4);
        send_bits(32'h0A03, 16);
        pulse_load();
        $display("reset seq: stb=%0d err=%0d int=%0d", stb_cnt - s0, err_cnt - e0, intensity);
        chk("post_rst_stb", 32'(stb_cnt - s0), 1);
        chk("post_rst_err", 32'(err_cnt - e0), 0);
        chk("post_rst_int", 32'(intensity), 3);
        chk("post_rst_decode", 32'(decode_mode), 0);

        // Daisy chain: dout sampled just before each of the 16 trailing serial clocks
        s0 = stb_cnt;
        e0 = err_cnt;
        chain = 16'h0C01;
        send_bits(32'h0C01, 16);
        for (int i = 15; i >= 0; i--) begin
            din = 1'b0;
            wait_cyc(4);
            $display("chain bit %0d: dout=%0d", 15 - i, dout);
            chk($sformatf("chain%0d", 15 - i), 32'(dout), 32'(chain[i]));
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
        end
        pulse_load();
        chk("chain_err", 32'(err_cnt - e0), 1);
        chk("chain_stb", 32'(stb_cnt - s0), 0);
        chk("chain_enable", 32'(enable), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
